// File: rtl/muxdff_scan_if.sv
// Bus bundle for muxdff_scan: packed channel data, select/mode/hold controls and registered outputs.
// The master modport is the driving side; the slave modport is the selector itself.
interface muxdff_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] d_i;
  logic [SEL_W-1:0]          sel_i;
  logic                      mode_i;
  logic                      hold_i;
  logic [WIDTH-1:0]          q_o;
  logic [SEL_W-1:0]          qChan_o;
  logic                      qValid_o;
  logic                      wrap_o;
  logic                      err_o;

  modport master (
    output d_i, sel_i, mode_i, hold_i,
    input  q_o, qChan_o, qValid_o, wrap_o, err_o
  );

  modport slave (
    input  d_i, sel_i, mode_i, hold_i,
    output q_o, qChan_o, qValid_o, wrap_o, err_o
  );
endinterface

// File: rtl/muxdff_scan.sv
// Registered N-channel W-bit selector with manual select or round-robin scan of programmable dwell.
// The scanner (SCAN state, dwell counter, scan pointer, Wrap) is compiled in only with MUXDFF_SCAN_EN.
module muxdff_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  muxdff_scan_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [SEL_W-1:0] qChan_q, qChan_d;
  logic             qValid_q, qValid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             selInRange;
  logic             scanReq;

  function automatic logic [WIDTH-1:0] chanWord(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [SEL_W-1:0]          idx
  );
    chanWord = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        chanWord = d[k*WIDTH +: WIDTH];
      end
    end
  endfunction

  assign selInRange = (int'(bus.sel_i) < CHANNELS);

`ifdef MUXDFF_SCAN_EN
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SEL_W-1:0] chan_q, chan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] curChan;
  logic [CNT_W-1:0] curCnt;

  assign scanReq = bus.mode_i;
`else
  logic unusedCfg;

  assign scanReq   = 1'b0;
  assign unusedCfg = ^{bus.mode_i, 32'(DWELL)};
`endif

  // Hold wins over everything; otherwise Mode picks scan or manual capture on every edge,
  // including the edge that leaves IDLE.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    qChan_d  = qChan_q;
    qValid_d = qValid_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
`ifdef MUXDFF_SCAN_EN
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    curChan  = chan_q;
    curCnt   = cnt_q;
`endif
    if (!bus.hold_i) begin
      if (scanReq) begin
`ifdef MUXDFF_SCAN_EN
        state_d = SCAN;
        // Entering scan restarts at channel 0; landing back on channel 0 with a fresh
        // dwell while already scanning can only follow a wrap, so that capture flags Wrap.
        if (state_q != SCAN) begin
          curChan = '0;
          curCnt  = '0;
        end else if ((chan_q == '0) && (cnt_q == '0)) begin
          wrap_d = 1'b1;
        end
        q_d      = chanWord(bus.d_i, curChan);
        qChan_d  = curChan;
        qValid_d = 1'b1;
        if (curCnt == CNT_W'(DWELL - 1)) begin
          cnt_d  = '0;
          chan_d = (curChan == SEL_W'(CHANNELS - 1)) ? '0 : curChan + SEL_W'(1);
        end else begin
          cnt_d  = curCnt + CNT_W'(1);
        end
`endif
      end else begin
        state_d = MANUAL;
        if (selInRange) begin
          q_d      = chanWord(bus.d_i, bus.sel_i);
          qChan_d  = bus.sel_i;
          qValid_d = 1'b1;
        end else begin
          err_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_q      <= '0;
      qChan_q  <= '0;
      qValid_q <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      qChan_q  <= qChan_d;
      qValid_q <= qValid_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

`ifdef MUXDFF_SCAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= '0;
      cnt_q  <= '0;
    end else begin
      chan_q <= chan_d;
      cnt_q  <= cnt_d;
    end
  end
`endif

  assign bus.q_o      = q_q;
  assign bus.qChan_o  = qChan_q;
  assign bus.qValid_o = qValid_q;
  assign bus.err_o    = err_q;
`ifdef MUXDFF_SCAN_EN
  assign bus.wrap_o   = wrap_q;
`else
  assign bus.wrap_o   = 1'b0;
`endif

endmodule
